// File: rtl/icache_inval_queue.sv
// I-cache invalidation queue: buffers L1.5 invalidations, drops back-to-back
// duplicates and escalates to a full-cache flush when the queue overflows.
module icache_inval_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 40,
  parameter int IDX_LSB = 4,
  parameter int IDX_MSB = 15,
  parameter int CNT_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       inval_valid_i,
  input  logic [ADDR_W-1:0]          inval_addr_i,
  output logic                       inval_valid_o,
  input  logic                       inval_ready_i,
  output logic [IDX_MSB-IDX_LSB:0]   inval_idx_o,
  output logic                       flush_req_o,
  input  logic                       flush_ack_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [CNT_W-1:0]           overflow_cnt_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int IDX_W = IDX_MSB - IDX_LSB + 1;

  logic [IDX_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_flush;
  logic [CNT_W-1:0] r_cnt;

  logic [PW-1:0]    w_occ;
  logic [PW-1:0]    w_last_ptr;
  logic [IDX_W-1:0] w_in_idx;
  logic [IDX_W-1:0] w_last_idx;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_valid;
  logic             w_deq;
  logic             w_last_leaving;
  logic             w_coalesce;
  logic             w_accept;
  logic             w_ovf;
  logic             w_push;
  logic             w_unused_addr;

  // Address bits outside the index slice are intentionally dropped.
  assign w_unused_addr = ^inval_addr_i;

  // Queue status and handshake decode, all from registered state.
  always_comb begin
    w_occ          = r_wptr - r_rptr;
    w_last_ptr     = r_wptr - PW'(1);
    w_in_idx       = inval_addr_i[IDX_MSB:IDX_LSB];
    w_last_idx     = r_mem[w_last_ptr[AW-1:0]];
    w_head_idx     = r_mem[r_rptr[AW-1:0]];
    w_empty        = (w_occ == '0);
    w_full         = (w_occ == PW'(DEPTH));
    w_valid        = !w_empty && !r_flush;
    w_deq          = w_valid && inval_ready_i;
    w_last_leaving = w_deq && (w_occ == PW'(1));
    w_coalesce     = !w_empty && !w_last_leaving
                     && (w_in_idx == w_last_idx);
    w_accept       = inval_valid_i && !r_flush && !w_coalesce;
    w_ovf          = w_accept && w_full && !w_deq;
    w_push         = w_accept && !w_ovf;
  end

  // Entry storage: only the forwarded index slice is kept.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_in_idx;
    end
  end

  // Pointers; an overflow empties the queue since the flush subsumes it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_ovf) begin
      r_rptr <= r_wptr;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // Flush request: raised on overflow, dropped on the ack edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_flush <= 1'b0;
    end else if (w_ovf) begin
      r_flush <= 1'b1;
    end else if (r_flush && flush_ack_i) begin
      r_flush <= 1'b0;
    end
  end

  // Saturating count of overflow escalations.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (w_ovf && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign inval_valid_o  = w_valid;
  assign inval_idx_o    = w_valid ? w_head_idx : '0;
  assign flush_req_o    = r_flush;
  assign occupancy_o    = w_occ;
  assign overflow_cnt_o = r_cnt;

endmodule

// File: tb/tb_icache_inval_queue.sv
// Directed bench for icache_inval_queue: reset, enqueue, coalesce,
// drain order, overflow/flush, full-queue pass-through and async reset.
module tb_icache_inval_queue;

  logic        clk;
  logic        rstn;
  logic        vld_i;
  logic [39:0] addr_i;
  logic        vld_o;
  logic        rdy_i;
  logic [11:0] idx_o;
  logic        flush_o;
  logic        ack_i;
  logic [2:0]  occ_o;
  logic [15:0] cnt_o;

  int ncmp = 0;
  int nerr = 0;

  icache_inval_queue dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .inval_valid_i  (vld_i),
    .inval_addr_i   (addr_i),
    .inval_valid_o  (vld_o),
    .inval_ready_i  (rdy_i),
    .inval_idx_o    (idx_o),
    .flush_req_o    (flush_o),
    .flush_ack_i    (ack_i),
    .occupancy_o    (occ_o),
    .overflow_cnt_o (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic v,
                        input logic [11:0] idx, input logic [2:0] occ,
                        input logic fl, input logic [15:0] cnt);
    chk({tag, ".valid"}, 32'(vld_o), 32'(v));
    chk({tag, ".idx"}, 32'(idx_o), 32'(idx));
    chk({tag, ".occ"}, 32'(occ_o), 32'(occ));
    chk({tag, ".flush"}, 32'(flush_o), 32'(fl));
    chk({tag, ".ovf"}, 32'(cnt_o), 32'(cnt));
  endtask

  task automatic pulse(input logic [11:0] idx);
    vld_i  = 1'b1;
    addr_i = {24'h008000, idx, 4'h0};
    tick();
    vld_i  = 1'b0;
  endtask

  initial begin
    rstn   = 1'b0;
    vld_i  = 1'b0;
    addr_i = '0;
    rdy_i  = 1'b0;
    ack_i  = 1'b0;
    #3;
    chk_st("in_reset", 0, 12'h000, 0, 0, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk_st("post_release", 0, 12'h000, 0, 0, 0);
    repeat (10) tick();
    chk_st("idle10", 0, 12'h000, 0, 0, 0);

    // single pulse, ready held high
    rdy_i  = 1'b1;
    vld_i  = 1'b1;
    addr_i = 40'h00_8000_1230;
    tick();
    vld_i  = 1'b0;
    chk_st("single.vis", 1, 12'h123, 1, 0, 0);
    tick();
    chk_st("single.gone", 0, 12'h000, 0, 0, 0);

    // coalesce then drain in order
    rdy_i = 1'b0;
    pulse(12'h010);
    chk_st("coal.a", 1, 12'h010, 1, 0, 0);
    pulse(12'h010);
    chk_st("coal.dup", 1, 12'h010, 1, 0, 0);
    pulse(12'h020);
    pulse(12'h010);
    chk_st("coal.three", 1, 12'h010, 3, 0, 0);
    rdy_i = 1'b1;
    tick();
    chk_st("drain.2", 1, 12'h020, 2, 0, 0);
    tick();
    chk_st("drain.3", 1, 12'h010, 1, 0, 0);
    tick();
    chk_st("drain.end", 0, 12'h000, 0, 0, 0);
    rdy_i = 1'b0;

    // overflow escalation and flush handshake
    pulse(12'h101);
    pulse(12'h102);
    pulse(12'h103);
    pulse(12'h104);
    chk_st("ovf.full", 1, 12'h101, 4, 0, 0);
    pulse(12'h105);
    chk_st("ovf.flush", 0, 12'h000, 0, 1, 1);
    pulse(12'h106);
    chk_st("ovf.drop", 0, 12'h000, 0, 1, 1);
    ack_i  = 1'b1;
    vld_i  = 1'b1;
    addr_i = {24'h008000, 12'h107, 4'h0};
    tick();
    ack_i = 1'b0;
    vld_i = 1'b0;
    chk_st("ovf.acked", 0, 12'h000, 0, 0, 1);
    pulse(12'h108);
    chk_st("ovf.resume", 1, 12'h108, 1, 0, 1);
    rdy_i = 1'b1;
    tick();
    rdy_i = 1'b0;
    chk_st("ovf.drained", 0, 12'h000, 0, 0, 1);

    // stray ack is ignored
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk_st("stray_ack", 0, 12'h000, 0, 0, 1);

    // full queue with simultaneous enqueue and dequeue
    pulse(12'h201);
    pulse(12'h202);
    pulse(12'h203);
    pulse(12'h204);
    chk_st("pass.full", 1, 12'h201, 4, 0, 1);
    rdy_i = 1'b1;
    pulse(12'h205);
    chk_st("pass.swap", 1, 12'h202, 4, 0, 1);
    tick();
    chk_st("pass.d1", 1, 12'h203, 3, 0, 1);
    tick();
    chk_st("pass.d2", 1, 12'h204, 2, 0, 1);
    tick();
    chk_st("pass.d3", 1, 12'h205, 1, 0, 1);
    tick();
    chk_st("pass.d4", 0, 12'h000, 0, 0, 1);
    rdy_i = 1'b0;

    // same index as a lone entry leaving this cycle is kept
    pulse(12'h300);
    rdy_i = 1'b1;
    pulse(12'h300);
    chk_st("leave.keep", 1, 12'h300, 1, 0, 1);
    tick();
    rdy_i = 1'b0;
    chk_st("leave.empty", 0, 12'h000, 0, 0, 1);

    // duplicate of last entry still queued behind a dequeue is dropped
    pulse(12'h310);
    pulse(12'h320);
    rdy_i = 1'b1;
    pulse(12'h320);
    chk_st("deq.coal", 1, 12'h320, 1, 0, 1);
    tick();
    rdy_i = 1'b0;
    chk_st("deq.empty", 0, 12'h000, 0, 0, 1);

    // async reset during a pending flush
    pulse(12'h401);
    pulse(12'h402);
    pulse(12'h403);
    pulse(12'h404);
    pulse(12'h405);
    chk_st("rst.flush", 0, 12'h000, 0, 1, 2);
    rstn = 1'b0;
    #1;
    chk_st("rst.async1", 0, 12'h000, 0, 0, 0);
    #3;
    rstn = 1'b1;
    tick();
    chk_st("rst.rel1", 0, 12'h000, 0, 0, 0);

    // async reset with three entries queued
    pulse(12'h501);
    pulse(12'h502);
    pulse(12'h503);
    chk_st("rst.three", 1, 12'h501, 3, 0, 0);
    rstn = 1'b0;
    #1;
    chk_st("rst.async2", 0, 12'h000, 0, 0, 0);
    #3;
    rstn = 1'b1;
    tick();
    chk_st("rst.rel2", 0, 12'h000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
